// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem read in flight,
// and filters out responses that belong to requests killed by a redirect.
package fetch_stage_pkg;
    typedef struct packed {
        logic        valid_s;
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic [63:0] order_s;
    } if_id_stage_reg_t;
endpackage

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic             imem_resp,
    output logic             fetch_resp_valid,
    output if_id_stage_reg_t if_id_reg
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] order_q, order_d;
    logic [31:0] pc_plus4;
    logic        issue;
    logic        valid;
    logic        resp_ok;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        order_d   = order_q;
        imem_addr = pc_q;
        issue     = 1'b0;
        valid     = 1'b0;
        resp_ok   = 1'b0;
        case (state_q)
            ISSUE: begin
                issue   = 1'b1;
                state_d = WAIT;
                if (redirect_valid) begin
                    imem_addr = redirect_pc;
                    pc_d      = redirect_pc;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // A response in the redirect cycle frees the slot, so the new target goes out immediately.
                    if (imem_resp) begin
                        issue     = 1'b1;
                        imem_addr = redirect_pc;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (imem_resp) begin
                    valid   = 1'b1;
                    resp_ok = 1'b1;
                    if (move) begin
                        issue     = 1'b1;
                        imem_addr = pc_plus4;
                        pc_d      = pc_plus4;
                        order_d   = order_q + 64'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ISSUE;
                end else begin
                    valid = 1'b1;
                    if (move) begin
                        issue     = 1'b1;
                        imem_addr = pc_plus4;
                        pc_d      = pc_plus4;
                        order_d   = order_q + 64'd1;
                        state_d   = WAIT;
                    end
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            order_q <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            order_q <= order_d;
        end
    end

    // Outputs are silenced while reset is held so nothing leaks during the async window.
    assign imem_rmask       = (issue && rst) ? 4'hF : 4'h0;
    assign fetch_resp_valid = resp_ok && rst;
    assign if_id_reg        = '{valid_s:   valid && rst,
                                pc_s:      pc_q,
                                pc_next_s: pc_plus4,
                                order_s:   order_q};

endmodule
